// File: rtl/rf_scoreboard.sv
// rf_scoreboard: multi-port integer register file with a per-register busy-bit
// scoreboard, optional write-to-read bypass and a RAW/WAW issue-hazard check.
// Sits between the instruction decoder and the ID/EX register; the writeback
// ports are driven from the WB/commit stage.
//
// Ports:
//   clk_i, rst_ni    core clock, asynchronous active-low reset
//   rs_addr_i        NUM_RD source addresses (AW bits each)
//   rs_used_i        per source: operand is actually consumed (gates RAW check)
//   rs_data_o        NUM_RD source read data (XLEN bits each)
//   rs_busy_o        per source: register has a pending unretired write
//   issue_valid_i    decode presents an instruction
//   issue_wen_i      instruction writes a destination
//   issue_rd_i       destination address
//   issue_ready_o    no hazard; instruction may issue
//   wb_en_i          writeback strobe per port
//   wb_addr_i        writeback address per port
//   wb_data_i        writeback data per port
//   flush_i          drops every pending write (clears all busy bits)
//   busy_vec_o       registered busy bits
//   busy_cnt_o       registered number of busy registers
module rf_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*AW-1:0]     rs_addr_i,
    input  logic [NUM_RD-1:0]        rs_used_i,
    output logic [NUM_RD*XLEN-1:0]   rs_data_o,
    output logic [NUM_RD-1:0]        rs_busy_o,
    input  logic                     issue_valid_i,
    input  logic                     issue_wen_i,
    input  logic [AW-1:0]            issue_rd_i,
    output logic                     issue_ready_o,
    input  logic [NUM_WR-1:0]        wb_en_i,
    input  logic [NUM_WR*AW-1:0]     wb_addr_i,
    input  logic [NUM_WR*XLEN-1:0]   wb_data_i,
    input  logic                     flush_i,
    output logic [NUM_REGS-1:0]      busy_vec_o,
    output logic [AW:0]              busy_cnt_o
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [AW:0]         cnt_nxt;
    logic                issue_fire;

    // ------------------------------------------------------------------
    // Register array. Entry 0 is never written, so it stays at its reset
    // value of zero and reads of x0 need no special casing for the array.
    // ------------------------------------------------------------------
    // NOTE: the array is reset here because the architecture requires all
    // registers to read zero after reset; that is why it cannot be a plain
    // reset-less RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            // Ascending port order: a later non-blocking assignment to the
            // same entry overrides, so the highest port index wins.
            for (int k = 0; k < NUM_WR; k++) begin
                if (wb_en_i[k] && wb_addr_i[k*AW +: AW] != '0)
                    regs[wb_addr_i[k*AW +: AW]] <= wb_data_i[k*XLEN +: XLEN];
            end
        end
    end

    // ------------------------------------------------------------------
    // Source read and busy, with optional same-cycle writeback bypass.
    // A bypass hit also masks busy: the value the consumer waits for is
    // on the writeback bus right now.
    // ------------------------------------------------------------------
    // NOTE: combinational blocks use blocking assignments and assign every
    // output a default first, so later loop iterations can override and no
    // latch is inferred.
    always_comb begin
        rs_data_o = '0;
        rs_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0] a;
            logic          hit;
            a   = rs_addr_i[i*AW +: AW];
            hit = 1'b0;
            rs_data_o[i*XLEN +: XLEN] = regs[a];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wb_en_i[k] && a != '0 && wb_addr_i[k*AW +: AW] == a) begin
                        rs_data_o[i*XLEN +: XLEN] = wb_data_i[k*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
            end
            rs_busy_o[i] = busy_q[a] & ~hit;
        end
    end

    // ------------------------------------------------------------------
    // Issue hazard check. WAW looks at the registered busy bit only; a
    // writeback retiring the old write this cycle does not release it.
    // ------------------------------------------------------------------
    always_comb begin
        logic raw;
        logic waw;
        raw = |(rs_used_i & rs_busy_o);
        waw = issue_wen_i & busy_q[issue_rd_i] & (issue_rd_i != '0);
        issue_ready_o = ~flush_i & ~raw & ~waw;
    end

    assign issue_fire = issue_valid_i & issue_ready_o & issue_wen_i & (issue_rd_i != '0);

    // Next-state busy: clears first, then the issue set (set wins over a
    // same-register clear), then flush wipes everything.
    always_comb begin
        busy_nxt = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wb_en_i[k] && wb_addr_i[k*AW +: AW] != '0)
                busy_nxt[wb_addr_i[k*AW +: AW]] = 1'b0;
        end
        if (issue_fire) busy_nxt[issue_rd_i] = 1'b1;
        if (flush_i)    busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= '0;
            busy_cnt_o <= '0;
        end else begin
            busy_q     <= busy_nxt;
            busy_cnt_o <= cnt_nxt;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard. Two instances share all inputs:
// dut (BYPASS=1) and dut_nb (BYPASS=0), both with two writeback ports.
// Expected values are pushed to a queue as stimulus is driven and popped
// when the outputs are sampled.
module tb_rf_scoreboard;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [AW-1:0]   rs_a0, rs_a1;
    logic [1:0]      rs_used;
    logic            issue_valid, issue_wen;
    logic [AW-1:0]   issue_rd;
    logic [1:0]      wb_en;
    logic [AW-1:0]   wb_a0, wb_a1;
    logic [XLEN-1:0] wb_d0, wb_d1;
    logic            flush;

    logic [2*XLEN-1:0] rs_data, rs_data_nb;
    logic [1:0]        rs_busy, rs_busy_nb;
    logic              ready, ready_nb;
    logic [NR-1:0]     busy_vec, busy_vec_nb;
    logic [AW:0]       busy_cnt, busy_cnt_nb;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk_i = ~clk_i;

    rf_scoreboard #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs_addr_i({rs_a1, rs_a0}), .rs_used_i(rs_used),
        .rs_data_o(rs_data), .rs_busy_o(rs_busy),
        .issue_valid_i(issue_valid), .issue_wen_i(issue_wen), .issue_rd_i(issue_rd),
        .issue_ready_o(ready),
        .wb_en_i(wb_en), .wb_addr_i({wb_a1, wb_a0}), .wb_data_i({wb_d1, wb_d0}),
        .flush_i(flush), .busy_vec_o(busy_vec), .busy_cnt_o(busy_cnt)
    );

    rf_scoreboard #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs_addr_i({rs_a1, rs_a0}), .rs_used_i(rs_used),
        .rs_data_o(rs_data_nb), .rs_busy_o(rs_busy_nb),
        .issue_valid_i(issue_valid), .issue_wen_i(issue_wen), .issue_rd_i(issue_rd),
        .issue_ready_o(ready_nb),
        .wb_en_i(wb_en), .wb_addr_i({wb_a1, wb_a0}), .wb_data_i({wb_d1, wb_d0}),
        .flush_i(flush), .busy_vec_o(busy_vec_nb), .busy_cnt_o(busy_cnt_nb)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic push(input string name, input logic [63:0] val);
        exp_q.push_back('{name: name, val: val});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rs_a0 = '0; rs_a1 = '0; rs_used = '0;
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
        wb_en = '0; wb_a0 = '0; wb_a1 = '0; wb_d0 = '0; wb_d1 = '0;
        flush = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 1'b0;
        rs_a0 = 5'd5; rs_a1 = 5'd0;
        push("rst_data", 64'h0); push("rst_ready", 64'h1);
        push("rst_cnt", 64'h0); push("rst_vec", 64'h0); push("rst_busy", 64'h0);
        #3;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready & ready_nb) !== e.val) $display("FAIL %s: observed %0b/%0b expected %0h", e.name, ready, ready_nb, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_cnt) !== e.val) $display("FAIL %s: observed %0d expected %0d", e.name, busy_cnt, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_busy) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, rs_busy, e.val); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        idle();
        issue(5'd5);
        push("bp_issue_ready", 64'h1); push("bp_issue_ready_nb", 64'h1);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready_nb) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready_nb, e.val); else n_pass++;
        tick();
        // Consumer of x5 while x5 is pending.
        idle();
        rs_a0 = 5'd5; rs_used = 2'b01;
        push("raw_busy", 64'h1); push("raw_ready", 64'h0); push("raw_ready_nb", 64'h0);
        push("raw_vec", 64'h20); push("raw_cnt", 64'h1);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_busy) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, rs_busy, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready_nb) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready_nb, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_cnt) !== e.val) $display("FAIL %s: observed %0d expected %0d", e.name, busy_cnt, e.val); else n_pass++;
        // Writeback of x5 in the same cycle.
        wb_en = 2'b01; wb_a0 = 5'd5; wb_d0 = 32'hDEADBEEF;
        push("bp_data", 64'hDEADBEEF); push("bp_busy", 64'h0); push("bp_ready", 64'h1);
        push("nb_ready", 64'h0); push("nb_busy", 64'h1); push("nb_data", 64'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data[31:0]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data[31:0], e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_busy[0]) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, rs_busy[0], e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready_nb) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready_nb, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_busy_nb[0]) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, rs_busy_nb[0], e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data_nb[31:0]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data_nb[31:0], e.val); else n_pass++;
        tick();
        // Cycle after writeback: busy cleared, array holds the value.
        wb_en = 2'b00;
        push("post_vec", 64'h0); push("post_cnt", 64'h0); push("post_ready_nb", 64'h1);
        push("post_data_nb", 64'hDEADBEEF); push("post_data", 64'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_cnt) !== e.val) $display("FAIL %s: observed %0d expected %0d", e.name, busy_cnt, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready_nb) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready_nb, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data_nb[31:0]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data_nb[31:0], e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data[31:0]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data[31:0], e.val); else n_pass++;
    endtask

    task automatic test_waw();
        idle();
        issue(5'd5);
        tick();
        // x5 busy: re-issuing rd=5 stalls, even with x5 on the writeback bus.
        wb_en = 2'b01; wb_a0 = 5'd5; wb_d0 = 32'h12345678;
        push("waw_ready", 64'h0); push("waw_ready_nb", 64'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready_nb) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready_nb, e.val); else n_pass++;
        tick();
        // Stalled issue was not accepted, writeback cleared x5. Now issue
        // rd=5 together with a writeback of x5: set wins.
        wb_d0 = 32'h9ABCDEF0;
        push("setclr_vec_before", 64'h0); push("setclr_ready", 64'h1);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready, e.val); else n_pass++;
        tick();
        idle();
        rs_a0 = 5'd5;
        push("setclr_vec", 64'h20); push("setclr_cnt", 64'h1); push("setclr_vec_nb", 64'h20);
        push("setclr_data", 64'h9ABCDEF0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_cnt) !== e.val) $display("FAIL %s: observed %0d expected %0d", e.name, busy_cnt, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec_nb) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec_nb, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data_nb[31:0]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data_nb[31:0], e.val); else n_pass++;
    endtask

    task automatic test_multi_wr();
        idle();
        rs_a0 = 5'd5; rs_a1 = 5'd7;
        wb_en = 2'b11; wb_a0 = 5'd7; wb_a1 = 5'd7; wb_d0 = 32'h11; wb_d1 = 32'h22;
        push("mw_bypass", 64'h22); push("mw_nobypass", 64'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data[63:32]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data[63:32], e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data_nb[63:32]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data_nb[63:32], e.val); else n_pass++;
        tick();
        wb_en = 2'b00;
        push("mw_array", 64'h22); push("mw_array_nb", 64'h22);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data[63:32]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data[63:32], e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data_nb[63:32]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data_nb[63:32], e.val); else n_pass++;
        // Issue rd=0 with wen and write x0 in the same cycle.
        issue(5'd0);
        rs_a1 = 5'd0;
        wb_en = 2'b01; wb_a0 = 5'd0; wb_d0 = 32'hFFFFFFFF;
        push("x0_bypass", 64'h0); push("x0_ready", 64'h1);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data[63:32]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data[63:32], e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready, e.val); else n_pass++;
        tick();
        idle();
        push("x0_vec", 64'h20); push("x0_cnt", 64'h1); push("x0_read", 64'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_cnt) !== e.val) $display("FAIL %s: observed %0d expected %0d", e.name, busy_cnt, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data_nb[63:32]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data_nb[63:32], e.val); else n_pass++;
    endtask

    task automatic test_flush();
        logic [AW-1:0] rds [3] = '{5'd3, 5'd4, 5'd9};
        idle();
        // Retire x5 while issuing the first of three destinations.
        wb_en = 2'b01; wb_a0 = 5'd5; wb_d0 = 32'h55;
        for (int i = 0; i < 3; i++) begin
            issue(rds[i]);
            tick();
            wb_en = 2'b00;
        end
        idle();
        push("fl_vec_pre", 64'h218); push("fl_cnt_pre", 64'h3);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_cnt) !== e.val) $display("FAIL %s: observed %0d expected %0d", e.name, busy_cnt, e.val); else n_pass++;
        // Flush with concurrent issue rd=10 and a writeback of x3.
        flush = 1'b1;
        issue(5'd10);
        wb_en = 2'b01; wb_a0 = 5'd3; wb_d0 = 32'hABCD0003;
        push("fl_ready", 64'h0); push("fl_ready_nb", 64'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready_nb) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready_nb, e.val); else n_pass++;
        tick();
        idle();
        rs_a0 = 5'd3;
        push("fl_vec", 64'h0); push("fl_cnt", 64'h0); push("fl_vec_nb", 64'h0);
        push("fl_wb_data", 64'hABCD0003);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_cnt) !== e.val) $display("FAIL %s: observed %0d expected %0d", e.name, busy_cnt, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec_nb) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec_nb, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data_nb[31:0]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data_nb[31:0], e.val); else n_pass++;
    endtask

    task automatic test_async_reset();
        idle();
        issue(5'd5);
        tick();
        idle();
        rs_a0 = 5'd3; rs_used = 2'b01;
        push("ar_vec_pre", 64'h20);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        // Reset asserted between clock edges: state must drop at once.
        #1;
        rst_ni = 1'b0;
        push("ar_vec", 64'h0); push("ar_cnt", 64'h0); push("ar_data", 64'h0); push("ar_ready", 64'h1);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_vec) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, busy_vec, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(busy_cnt) !== e.val) $display("FAIL %s: observed %0d expected %0d", e.name, busy_cnt, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(rs_data[31:0]) !== e.val) $display("FAIL %s: observed %0h expected %0h", e.name, rs_data[31:0], e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (64'(ready) !== e.val) $display("FAIL %s: observed %0b expected %0h", e.name, ready, e.val); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_waw();
        test_multi_wr();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
